// File: rtl/jal_link_tracker_pkg.sv
// Shared definitions for the jal link-forwarding tracker: the default link
// offset, the {valid, link} stage-slot layout and the E/M/W slot indices.
package jal_link_tracker_pkg;

  // Link address is PC+8: the jal itself plus its delay slot.
  localparam int LINK_OFFSET_DEF = 8;

  // Slot layout at the default datapath width.
  localparam int SLOT_W = 32;

  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] link;
  } jal_slot_t;

  // Indices of the in-flight slots, oldest last.
  localparam int STG_E   = 0;
  localparam int STG_M   = 1;
  localparam int STG_W   = 2;
  localparam int NUM_STG = 3;

endpackage

// File: rtl/jal_link_tracker_stage_reg.sv
// One {valid, link} pipeline slot of the jal tracker. It always advances;
// the only thing that clears it is the asynchronous reset.
module jal_stage_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_link,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_link
);

  logic             r_valid;
  logic [WIDTH-1:0] r_link;

  // Capture the incoming slot every cycle; reset drops any in-flight jal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_link  <= '0;
    end else begin
      r_valid <= i_valid;
      r_link  <= i_link;
    end
  end

  assign o_valid = r_valid;
  assign o_link  = r_link;

endmodule

// File: rtl/jal_link_tracker.sv
// Producer side of the jal link-forwarding path: tracks jals through E/M/W,
// forwards the youngest valid link to the decode jr mux, requests the $ra
// write at W and counts retired jals with a saturating counter.
module jal_link_tracker
  import jal_link_tracker_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LINK_OFFSET = LINK_OFFSET_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_d,
  input  logic             is_jal_d,
  input  logic             stall_d,
  input  logic             flush_d,
  output logic             forward_jal,
  output logic [WIDTH-1:0] link_fwd,
  output logic             ra_we_w,
  output logic [WIDTH-1:0] ra_wdata_w,
  output logic [CNT_W-1:0] jal_retired
);

  // A stalled or squashed decode instruction enters E as a bubble.
  logic             w_valid_d;
  logic [WIDTH-1:0] w_link_d;

  assign w_valid_d = is_jal_d & ~stall_d & ~flush_d;
  // Wraps modulo 2^WIDTH; loaded even for bubbles since valid gates its use.
  assign w_link_d  = pc_d + WIDTH'(LINK_OFFSET);

  logic             w_slot_vin  [NUM_STG];
  logic [WIDTH-1:0] w_slot_lin  [NUM_STG];
  logic             w_slot_v    [NUM_STG];
  logic [WIDTH-1:0] w_slot_l    [NUM_STG];

  // E takes from decode; M and W take from the slot before them.
  for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_slot
    if (gi == STG_E) begin : g_head
      assign w_slot_vin[gi] = w_valid_d;
      assign w_slot_lin[gi] = w_link_d;
    end else begin : g_tail
      assign w_slot_vin[gi] = w_slot_v[gi-1];
      assign w_slot_lin[gi] = w_slot_l[gi-1];
    end

    jal_stage_reg #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_slot_vin[gi]),
      .i_link  (w_slot_lin[gi]),
      .o_valid (w_slot_v[gi]),
      .o_link  (w_slot_l[gi])
    );
  end

  // Youngest valid jal wins the forward path (E over M over W).
  always_comb begin
    forward_jal = w_slot_v[STG_E] | w_slot_v[STG_M] | w_slot_v[STG_W];
    link_fwd    = '0;
    if (w_slot_v[STG_E]) begin
      link_fwd = w_slot_l[STG_E];
    end else if (w_slot_v[STG_M]) begin
      link_fwd = w_slot_l[STG_M];
    end else if (w_slot_v[STG_W]) begin
      link_fwd = w_slot_l[STG_W];
    end
  end

  // $ra write request comes straight from the W slot; data zeroed when idle.
  always_comb begin
    ra_we_w    = w_slot_v[STG_W];
    ra_wdata_w = '0;
    if (w_slot_v[STG_W]) begin
      ra_wdata_w = w_slot_l[STG_W];
    end
  end

  logic [CNT_W-1:0] r_retired;

  // A jal retires on the edge where M moves into W; hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_slot_v[STG_M] && (r_retired != '1)) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign jal_retired = r_retired;

endmodule

// File: tb/tb_jal_link_tracker.sv
// Self-checking bench for jal_link_tracker: a vector table driven through a
// scoreboard queue, plus hand sequences for async reset and saturation.
module tb_jal_link_tracker;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_d;
  logic        is_jal_d;
  logic        stall_d;
  logic        flush_d;

  logic        forward_jal;
  logic [31:0] link_fwd;
  logic        ra_we_w;
  logic [31:0] ra_wdata_w;
  logic [15:0] jal_retired;

  logic        s_forward_jal;
  logic [31:0] s_link_fwd;
  logic        s_ra_we_w;
  logic [31:0] s_ra_wdata_w;
  logic [3:0]  s_jal_retired;

  jal_link_tracker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_d        (pc_d),
    .is_jal_d    (is_jal_d),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .forward_jal (forward_jal),
    .link_fwd    (link_fwd),
    .ra_we_w     (ra_we_w),
    .ra_wdata_w  (ra_wdata_w),
    .jal_retired (jal_retired)
  );

  jal_link_tracker #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_d        (pc_d),
    .is_jal_d    (is_jal_d),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .forward_jal (s_forward_jal),
    .link_fwd    (s_link_fwd),
    .ra_we_w     (s_ra_we_w),
    .ra_wdata_w  (s_ra_wdata_w),
    .jal_retired (s_jal_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        jal;
    logic        stall;
    logic        flush;
    logic        e_fwd;
    logic [31:0] e_link;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic        e_fwd;
    logic [31:0] e_link;
    logic        e_we;
    logic [31:0] e_wdata;
    int          e_cnt;
  } exp_t;

  int   checks;
  int   failures;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, queue its expectation, then check
  // the outputs just after the following rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n    = v.rst_n;
    pc_d     = v.pc;
    is_jal_d = v.jal;
    stall_d  = v.stall;
    flush_d  = v.flush;
    sb_q.push_back('{v.e_fwd, v.e_link, v.e_we, v.e_wdata, v.e_cnt});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("v%0d_fwd", idx),    {31'd0, forward_jal},   {31'd0, e.e_fwd});
    check($sformatf("v%0d_link", idx),   link_fwd,               e.e_link);
    check($sformatf("v%0d_we", idx),     {31'd0, ra_we_w},       {31'd0, e.e_we});
    check($sformatf("v%0d_wdata", idx),  ra_wdata_w,             e.e_wdata);
    check($sformatf("v%0d_cnt", idx),    {16'd0, jal_retired},   e.e_cnt);
    check($sformatf("v%0d_s_fwd", idx),  {31'd0, s_forward_jal}, {31'd0, e.e_fwd});
    check($sformatf("v%0d_s_link", idx), s_link_fwd,             e.e_link);
    check($sformatf("v%0d_s_we", idx),   {31'd0, s_ra_we_w},     {31'd0, e.e_we});
    check($sformatf("v%0d_s_wdata", idx), s_ra_wdata_w,          e.e_wdata);
    check($sformatf("v%0d_s_cnt", idx),  {28'd0, s_jal_retired}, e.e_cnt);
    $display("vec %0d rst_n=%0b pc=0x%08h jal=%0b stall=%0b flush=%0b -> fwd=%0b link=0x%08h we=%0b wdata=0x%08h cnt=%0d",
             idx, v.rst_n, v.pc, v.jal, v.stall, v.flush,
             forward_jal, link_fwd, ra_we_w, ra_wdata_w, jal_retired);
  endtask

  vec_t vecs[$];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    pc_d     = '0;
    is_jal_d = 1'b0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;

    //        rst  pc            jal stl fls  fwd link          we wdata         cnt
    // reset held with jal toggling, then release
    vecs.push_back('{1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});
    vecs.push_back('{1'b0, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});
    // single jal
    vecs.push_back('{1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0018, 1'b0, 32'h0,         0});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0018, 1'b0, 32'h0,         0});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0018, 1});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1});
    // back-to-back jals
    vecs.push_back('{1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0108, 1'b0, 32'h0,         1});
    vecs.push_back('{1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_010C, 1'b0, 32'h0,         1});
    vecs.push_back('{1'b1, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0108, 2});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_010C, 3});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0110, 4});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    // stall, flush, both: nothing enters the pipeline
    vecs.push_back('{1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    vecs.push_back('{1'b1, 32'h0000_0204, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    vecs.push_back('{1'b1, 32'h0000_0208, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         4});
    // wrapping link, then reset while the jal sits in M: no $ra write
    vecs.push_back('{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         4});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,         4});
    vecs.push_back('{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});
    vecs.push_back('{1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         0});

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset: outputs clear mid-cycle without waiting for an edge.
    @(negedge clk);
    pc_d     = 32'h0000_1000;
    is_jal_d = 1'b1;
    @(negedge clk);
    is_jal_d = 1'b0;
    #2;
    check("async_pre_fwd", {31'd0, forward_jal}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_fwd",  {31'd0, forward_jal}, 32'd0);
    check("async_link", link_fwd, 32'h0);
    $display("async reset mid-cycle -> fwd=%0b link=0x%08h cnt=%0d", forward_jal, link_fwd, jal_retired);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: 20 back-to-back jals; the 4-bit counter stops at 15.
    for (int k = 1; k <= 23; k++) begin
      int retired;
      @(negedge clk);
      pc_d     = 32'h0000_2000 + 32'(k * 4);
      is_jal_d = (k <= 20);
      @(posedge clk);
      #1;
      retired = (k >= 3) ? ((k - 2 > 20) ? 20 : k - 2) : 0;
      check($sformatf("sat%0d_cnt16", k), {16'd0, jal_retired}, retired);
      check($sformatf("sat%0d_cnt4", k), {28'd0, s_jal_retired}, (retired > 15) ? 15 : retired);
      check($sformatf("sat%0d_fwd", k), {31'd0, s_forward_jal}, (k <= 22) ? 32'd1 : 32'd0);
      $display("sat cycle %0d jal=%0b -> cnt16=%0d cnt4=%0d fwd=%0b", k, is_jal_d, jal_retired, s_jal_retired, s_forward_jal);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
